fib_multi_engine: RTL and testbench



---
 rtl/fib_multi_pkg.sv | 28 ++
 rtl/fib_channel.sv | 117 +++++++++++
 rtl/fib_multi_engine.sv | 81 ++++++++
 tb/tb_fib_multi_engine.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_multi_pkg.sv
// Shared types, defaults and helpers for the multi-channel Fibonacci engine.
package fib_multi_pkg;

  localparam int DEF_WIDTH    = 30;
  localparam int DEF_CHANNELS = 4;
  localparam int DEF_TAP_STEP = 8;
  localparam int DEF_RATES    = 6;

  // The 3-bit rate select addresses up to eight tick lines; unused ones stay low.
  localparam int RATE_SLOTS = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WRAP,
    HALT
  } ch_state_t;

  // Prescaler mask for a rate: the low rate*tap_step bits set.
  function automatic logic [63:0] tick_for(input int rate, input int tap_step);
    return (64'd1 << (rate * tap_step)) - 64'd1;
  endfunction

  function automatic logic [2:0] clamp_rate(input logic [2:0] rate, input int rates);
    return (32'(rate) >= rates) ? 3'(rates - 1) : rate;
  endfunction

endpackage

// File: rtl/fib_channel.sv
// One Fibonacci generator: run/wrap/halt state machine, sticky overflow and step pulse.
module fib_channel
  import fib_multi_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int RATES = DEF_RATES
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [RATE_SLOTS-1:0] ticks,
  input  logic                  sel,
  input  logic                  cfg_on,
  input  logic [2:0]            cfg_rate,
  input  logic                  cfg_wrap,
  input  logic                  cfg_restart,
  input  logic                  cfg_clr,
  output logic [WIDTH-1:0]      value,
  output logic                  step,
  output logic                  ovf,
  output logic                  halted
);

  ch_state_t        state, state_d;
  logic [WIDTH-1:0] a, a_d, b, b_d;
  logic [WIDTH:0]   sum;
  logic [2:0]       rate;
  logic             on, wrap;
  logic             resume_halt, resume_d;
  logic             step_d, ovf_set;
  logic             tick, restart;

  assign restart = sel & cfg_restart;
  assign tick    = ticks[rate];
  assign sum     = {1'b0, a} + {1'b0, b};

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state;
    a_d      = a;
    b_d      = b;
    resume_d = resume_halt;
    step_d   = 1'b0;
    ovf_set  = 1'b0;
    if (restart) begin
      a_d      = '0;
      b_d      = WIDTH'(1);
      resume_d = 1'b0;
      state_d  = cfg_on ? RUN : IDLE;
    end else if (!on) begin
      // Pausing a halted channel remembers the halt so re-enabling lands back in it.
      state_d = IDLE;
      if (state == HALT) resume_d = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          state_d  = resume_halt ? HALT : RUN;
          resume_d = 1'b0;
        end
        RUN: begin
          if (tick) begin
            a_d    = b;
            step_d = 1'b1;
            if (sum[WIDTH]) begin
              ovf_set = 1'b1;
              state_d = wrap ? WRAP : HALT;
            end else begin
              b_d = sum[WIDTH-1:0];
            end
          end
        end
        WRAP: begin
          if (tick) begin
            a_d     = '0;
            b_d     = WIDTH'(1);
            step_d  = 1'b1;
            state_d = RUN;
          end
        end
        HALT:    state_d = HALT;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: registers take non-blocking assignments so every flop samples pre-edge values together.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      a           <= '0;
      b           <= WIDTH'(1);
      on          <= 1'b0;
      rate        <= '0;
      wrap        <= 1'b0;
      resume_halt <= 1'b0;
      step        <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      state       <= state_d;
      a           <= a_d;
      b           <= b_d;
      resume_halt <= resume_d;
      step        <= step_d;
      // A fresh overflow beats a clear arriving in the same cycle.
      if (ovf_set)            ovf <= 1'b1;
      else if (sel && cfg_clr) ovf <= 1'b0;
      if (sel) begin
        on   <= cfg_on;
        rate <= clamp_rate(cfg_rate, RATES);
        wrap <= cfg_wrap;
      end
    end
  end

  assign value  = a;
  assign halted = (state == HALT);

endmodule

// File: rtl/fib_multi_engine.sv
// CHANNELS independent Fibonacci generators paced by one shared prescaler.
// Optional FIB_MULTI_IRQ_EN adds irq_mask and a registered masked-overflow interrupt.
module fib_multi_engine
  import fib_multi_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int TAP_STEP = DEF_TAP_STEP,
  parameter int RATES    = DEF_RATES
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cfg_we,
  input  logic [3:0]                cfg_ch,
  input  logic                      cfg_on,
  input  logic [2:0]                cfg_rate,
  input  logic                      cfg_wrap,
  input  logic                      cfg_restart,
  input  logic                      cfg_clr,
  output logic [CHANNELS*WIDTH-1:0] value,
  output logic [CHANNELS-1:0]       step,
  output logic [CHANNELS-1:0]       ovf,
  output logic [CHANNELS-1:0]       halted,
`ifdef FIB_MULTI_IRQ_EN
  input  logic [CHANNELS-1:0]       irq_mask,
`endif
  output logic                      irq
);

  // Rate 0 needs no prescaler bits, so RATES >= 2 keeps the counter non-empty.
  localparam int PW = (RATES - 1) * TAP_STEP;

  logic [PW-1:0]         presc;
  logic [RATE_SLOTS-1:0] ticks;

  always_ff @(posedge clk) begin
    if (!reset_n) presc <= '0;
    else          presc <= presc + PW'(1);
  end

  for (genvar r = 0; r < RATE_SLOTS; r++) begin : g_tick
    if (r < RATES) begin : g_used
      localparam logic [PW-1:0] MASK = PW'(tick_for(r, TAP_STEP));
      assign ticks[r] = ((presc & MASK) == MASK);
    end else begin : g_unused
      assign ticks[r] = 1'b0;
    end
  end

  // Indices at or above CHANNELS match no copy, so such writes are dropped.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    fib_channel #(
      .WIDTH(WIDTH),
      .RATES(RATES)
    ) u_channel (
      .clk        (clk),
      .reset_n    (reset_n),
      .ticks      (ticks),
      .sel        (cfg_we && (cfg_ch == 4'(i))),
      .cfg_on     (cfg_on),
      .cfg_rate   (cfg_rate),
      .cfg_wrap   (cfg_wrap),
      .cfg_restart(cfg_restart),
      .cfg_clr    (cfg_clr),
      .value      (value[i*WIDTH +: WIDTH]),
      .step       (step[i]),
      .ovf        (ovf[i]),
      .halted     (halted[i])
    );
  end

`ifdef FIB_MULTI_IRQ_EN
  always_ff @(posedge clk) begin
    if (!reset_n) irq <= 1'b0;
    else          irq <= |(ovf & irq_mask);
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_fib_multi_engine.sv
// Self-checking bench for fib_multi_engine: directed scenarios plus a per-cycle behavioural model.
module tb_fib_multi_engine;

  localparam int W         = 8;
  localparam int NCH       = 4;
  localparam int TAP       = 2;
  localparam int NR        = 6;
  localparam int PRESC_MOD = 1 << ((NR - 1) * TAP);
`ifdef FIB_MULTI_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           cfg_we = 1'b0, cfg_on = 1'b0, cfg_wrap = 1'b0;
  logic           cfg_restart = 1'b0, cfg_clr = 1'b0;
  logic [3:0]     cfg_ch = '0;
  logic [2:0]     cfg_rate = '0;
  logic [NCH-1:0] mask_tb = '0;
  logic [NCH*W-1:0] value;
  logic [NCH-1:0] step, ovf, halted;
  logic           irq;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  int seq1[$] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233};
  int seq2[$] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 0, 1, 1, 2};
  int seq4[$] = '{1, 1, 2};
  int seq5[$] = '{21};

  fib_multi_engine #(
    .WIDTH(W), .CHANNELS(NCH), .TAP_STEP(TAP), .RATES(NR)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_on     (cfg_on),
    .cfg_rate   (cfg_rate),
    .cfg_wrap   (cfg_wrap),
    .cfg_restart(cfg_restart),
    .cfg_clr    (cfg_clr),
    .value      (value),
    .step       (step),
    .ovf        (ovf),
    .halted     (halted),
`ifdef FIB_MULTI_IRQ_EN
    .irq_mask   (mask_tb),
`endif
    .irq        (irq)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_RUN, M_WRAP, M_HALT} mph_t;
  int   m_a[NCH], m_b[NCH], m_rate[NCH];
  bit   m_on[NCH], m_wrap[NCH], m_resume[NCH], m_step[NCH], m_ovf[NCH];
  mph_t m_ph[NCH];
  bit   m_irq;
  int   m_presc;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_a[c] = 0; m_b[c] = 1; m_rate[c] = 0;
      m_on[c] = 0; m_wrap[c] = 0; m_resume[c] = 0; m_step[c] = 0; m_ovf[c] = 0;
      m_ph[c] = M_IDLE;
    end
    m_irq = 0;
    m_presc = 0;
  endtask

  task automatic model_channel(input int c);
    bit sel = cfg_we && (int'(cfg_ch) == c);
    int period = 1 << (m_rate[c] * TAP);
    bit tick = (m_presc % period) == (period - 1);
    bit set_ovf = 0;
    int sum;
    m_step[c] = 0;
    if (sel && cfg_restart) begin
      m_a[c] = 0; m_b[c] = 1; m_resume[c] = 0;
      m_ph[c] = cfg_on ? M_RUN : M_IDLE;
    end else if (!m_on[c]) begin
      if (m_ph[c] == M_HALT) m_resume[c] = 1;
      m_ph[c] = M_IDLE;
    end else if (m_ph[c] == M_IDLE) begin
      m_ph[c] = m_resume[c] ? M_HALT : M_RUN;
      m_resume[c] = 0;
    end else if (m_ph[c] == M_RUN && tick) begin
      sum = m_a[c] + m_b[c];
      m_a[c] = m_b[c];
      m_step[c] = 1;
      if (sum >= (1 << W)) begin
        set_ovf = 1;
        m_ph[c] = m_wrap[c] ? M_WRAP : M_HALT;
      end else begin
        m_b[c] = sum;
      end
    end else if (m_ph[c] == M_WRAP && tick) begin
      m_a[c] = 0; m_b[c] = 1; m_step[c] = 1; m_ph[c] = M_RUN;
    end
    if (set_ovf) m_ovf[c] = 1;
    else if (sel && cfg_clr) m_ovf[c] = 0;
    if (sel) begin
      m_on[c] = cfg_on;
      m_rate[c] = (int'(cfg_rate) >= NR) ? NR - 1 : int'(cfg_rate);
      m_wrap[c] = cfg_wrap;
    end
  endtask

  task automatic model_edge();
    bit irq_n = 0;
    if (!reset_n) begin
      model_reset();
    end else begin
      for (int c = 0; c < NCH; c++) if (m_ovf[c] && mask_tb[c]) irq_n = 1;
      for (int c = 0; c < NCH; c++) model_channel(c);
      m_irq = IRQ_ON && irq_n;
      m_presc = (m_presc + 1) % PRESC_MOD;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_edge();
  end

  // Compare process: every falling edge once reset has been applied.
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      for (int c = 0; c < NCH; c++) begin
        check($sformatf("cmp_value%0d", c), 32'(value[c*W +: W]), 32'(m_a[c]));
        check($sformatf("cmp_step%0d", c), 32'(step[c]), 32'(m_step[c]));
        check($sformatf("cmp_ovf%0d", c), 32'(ovf[c]), 32'(m_ovf[c]));
        check($sformatf("cmp_halted%0d", c), 32'(halted[c]), 32'(m_ph[c] == M_HALT));
      end
      check("cmp_irq", 32'(irq), 32'(m_irq));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int ch, input bit on, input int rate, input bit wrap,
                           input bit restart, input bit clr);
    cfg_we = 1'b1; cfg_ch = 4'(ch); cfg_on = on; cfg_rate = 3'(rate);
    cfg_wrap = wrap; cfg_restart = restart; cfg_clr = clr;
    cyc();
    cfg_we = 1'b0; cfg_restart = 1'b0; cfg_clr = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_value"}, 32'(value), 32'd0);
    check({tag, "_step"}, 32'(step), 32'd0);
    check({tag, "_ovf"}, 32'(ovf), 32'd0);
    check({tag, "_halted"}, 32'(halted), 32'd0);
    check({tag, "_irq"}, 32'(irq), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    cyc();
    cmp_en = 1'b1;
    check_zero(tag);
    reset_n = 1'b1;
  endtask

  task automatic expect_seq(input int c, input int want[$], input string name);
    int n = 0;
    for (int k = 0; k < 120 && n < want.size(); k++) begin
      cyc();
      if (step[c] === 1'b1) begin
        check($sformatf("%s[%0d]", name, n), 32'(value[c*W +: W]), 32'(want[n]));
        n++;
      end
    end
    check({name, "_count"}, 32'(n), 32'(want.size()));
  endtask

  task automatic wait_until_val(input int c, input int v, input string name);
    int k = 0;
    while (value[c*W +: W] !== W'(v) && k < 60) begin
      cyc();
      k++;
    end
    check(name, 32'(value[c*W +: W]), 32'(v));
  endtask

  task automatic wait_bit(input int c, input bit use_ovf, input string name);
    int k = 0;
    while ((use_ovf ? ovf[c] : step[c]) !== 1'b1 && k < 60) begin
      cyc();
      k++;
    end
    check(name, 32'(use_ovf ? ovf[c] : step[c]), 32'd1);
  endtask

  initial begin
    int t[3];
    int n, cnt0, cnt1, cnt;

    // 1: stop on overflow
    do_reset("t1_reset");
    cfg_write(0, 1, 0, 0, 0, 0);
    check("t1_start_val", 32'(value[7:0]), 32'd0);
    expect_seq(0, seq1, "t1_seq");
    cyc(); cyc();
    check("t1_hold_val", 32'(value[7:0]), 32'd233);
    check("t1_halted", 32'(halted[0]), 32'd1);
    check("t1_ovf", 32'(ovf[0]), 32'd1);
    check("t1_nostep", 32'(step[0]), 32'd0);

    // 2: wrap on overflow, sticky flag until cleared
    do_reset("t2_reset");
    cfg_write(0, 1, 0, 1, 0, 0);
    expect_seq(0, seq2, "t2_seq");
    check("t2_ovf_sticky", 32'(ovf[0]), 32'd1);
    check("t2_not_halted", 32'(halted[0]), 32'd0);
    cfg_write(0, 1, 0, 1, 0, 1);
    check("t2_ovf_clr", 32'(ovf[0]), 32'd0);

    // 3: slow rate on ch1 alongside full rate on ch0
    do_reset("t3_reset");
    cfg_write(1, 1, 2, 0, 0, 0);
    cfg_write(0, 1, 0, 1, 0, 0);
    t = '{0, 0, 0};
    n = 0;
    for (int k = 0; k < 120 && n < 3; k++) begin
      cyc();
      if (step[1] === 1'b1) begin
        t[n] = k;
        n++;
      end
    end
    check("t3_pulses", 32'(n), 32'd3);
    check("t3_gap0", 32'(t[1] - t[0]), 32'd16);
    check("t3_gap1", 32'(t[2] - t[1]), 32'd16);
    cnt0 = 0; cnt1 = 0;
    repeat (32) begin
      cyc();
      if (step[0] === 1'b1) cnt0++;
      if (step[1] === 1'b1) cnt1++;
    end
    check("t3_ch0_steps", 32'(cnt0), 32'd32);
    check("t3_ch1_steps", 32'(cnt1), 32'd2);

    // 4: restart coinciding with a tick at value 21
    do_reset("t4_reset");
    cfg_write(2, 1, 0, 0, 0, 0);
    wait_until_val(2, 21, "t4_reach21");
    cfg_write(2, 1, 0, 0, 1, 0);
    check("t4_restart_val", 32'(value[23:16]), 32'd0);
    check("t4_restart_nostep", 32'(step[2]), 32'd0);
    expect_seq(2, seq4, "t4_seq");

    // 5: pause, out-of-range write, resume
    do_reset("t5_reset");
    cfg_write(3, 1, 0, 0, 0, 0);
    wait_until_val(3, 8, "t5_reach8");
    cfg_write(3, 0, 0, 0, 0, 0);
    check("t5_last", 32'(value[31:24]), 32'd13);
    cnt = 0;
    repeat (50) begin
      cyc();
      if (step[3] === 1'b1) cnt++;
    end
    check("t5_paused_steps", 32'(cnt), 32'd0);
    check("t5_hold", 32'(value[31:24]), 32'd13);
    cfg_write(15, 1, 0, 1, 1, 1);
    cnt = 0;
    repeat (3) begin
      cyc();
      if (step !== '0) cnt++;
    end
    check("t5_alias_steps", 32'(cnt), 32'd0);
    check("t5_alias_val", 32'(value), 32'(13 << 24));
    cfg_write(3, 1, 0, 0, 0, 0);
    expect_seq(3, seq5, "t5_resume");

    // 6: reset mid-run, then interrupt masking
    do_reset("t6_reset0");
    cfg_write(0, 1, 0, 0, 0, 0);
    cfg_write(1, 1, 0, 1, 0, 0);
    repeat (20) cyc();
    check("t6_pre_halted", 32'(halted[0]), 32'd1);
    check("t6_pre_ovf", 32'(ovf[0]), 32'd1);
    do_reset("t6_midreset");
    mask_tb = 4'b0001;
    cfg_write(1, 1, 0, 0, 0, 0);
    wait_bit(1, 1'b1, "t6_ovf1");
    repeat (3) cyc();
    check("t6_irq_masked", 32'(irq), 32'd0);
    cfg_write(0, 1, 0, 0, 0, 0);
    wait_bit(0, 1'b1, "t6_ovf0");
    check("t6_irq_lag", 32'(irq), 32'd0);
    cyc();
    check("t6_irq_rise", 32'(irq), 32'(IRQ_ON));
    cfg_write(0, 1, 0, 0, 0, 1);
    check("t6_ovf0_clr", 32'(ovf[0]), 32'd0);
    check("t6_irq_hold", 32'(irq), 32'(IRQ_ON));
    cyc();
    check("t6_irq_drop", 32'(irq), 32'd0);
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
